// File: rtl/pipe_pkg.sv
// Shared constants for the 5-stage pipeline control slice.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Contents: architectural zero register, stage indices (IF..WB, also the bit
// positions in the controller's valid vector), default multiply occupancy.
package pipe_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;
  localparam int NUM_STG = 5;

  localparam int MUL_CYCLES_DEF = 3;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard compare between the ID instruction and a load sitting in EXE.
// Latency: purely combinational, zero cycles.
// Backpressure: none itself; its output is the ID stage's not-ready signal.
// Ports:
//   id_rs/id_rt (+_used)     source registers read by the ID instruction
//   exe_rdc (+_valid)        destination written by the EXE instruction
//   exe_lw_instr             EXE instruction is a load
//   id_valid/exe_valid       live-instruction qualifiers
//   load_use_stall           ID must wait for the load data
module load_use_detect
  import pipe_pkg::*;
(
  input  logic       id_valid,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic       exe_valid,
  input  logic [4:0] exe_rdc,
  input  logic       exe_rdc_valid,
  input  logic       exe_lw_instr,
  output logic       load_use_stall
);

  logic exe_load_dst;
  logic rs_hit;
  logic rt_hit;

  // $0 is hardwired, so a load targeting it can never feed a consumer.
  assign exe_load_dst = exe_valid && exe_lw_instr && exe_rdc_valid && (exe_rdc != REG_ZERO);
  assign rs_hit       = id_rs_used && (id_rs == exe_rdc);
  assign rt_hit       = id_rt_used && (id_rt == exe_rdc);

  assign load_use_stall = id_valid && exe_load_dst && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Valid/allowin handshake controller for the IF/ID/EXE/MEM/WB pipeline.
// Latency: valids registered (1 cycle); allowins, pc_we, load_use_stall combinational.
// Backpressure: allowin ripples back from WB; a stage stalls when it is busy and not done.
// Ports:
//   clk, rst (sync, active-high), flush (kills IF/ID/EXE)
//   id_*/exe_* hazard and mul info, mem_ready_go (MEM done)
//   pc_we, <stage>_allowin, <stage>_valid, load_use_stall
// Optional build macro PIPE_CTRL_PERF_CNT_EN adds stall_cnt and bubble_cnt outputs.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,  // >= 1, cycles a mul spends in EXE
  parameter int CNT_W      = 2                // 2**CNT_W >= MUL_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_rs_used,
  input  logic        id_rt_used,
  input  logic [4:0]  exe_rdc,
  input  logic        exe_rdc_valid,
  input  logic        exe_lw_instr,
  input  logic        exe_mul_instr,
  input  logic        mem_ready_go,
  output logic        pc_we,
  output logic        if_allowin,
  output logic        id_allowin,
  output logic        exe_allowin,
  output logic        mem_allowin,
  output logic        wb_allowin,
  output logic        if_valid,
  output logic        id_valid,
  output logic        exe_valid,
  output logic        mem_valid,
  output logic        wb_valid,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic        load_use_stall
);

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);

  logic [NUM_STG-1:0] vld_q;
  logic [CNT_W-1:0]   mul_cnt;

  logic if_rg;
  logic id_rg;
  logic exe_rg;
  logic mem_rg;

  assign if_valid  = vld_q[STG_IF];
  assign id_valid  = vld_q[STG_ID];
  assign exe_valid = vld_q[STG_EXE];
  assign mem_valid = vld_q[STG_MEM];
  assign wb_valid  = vld_q[STG_WB];

  load_use_detect u_lud (
    .id_valid       (id_valid),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_used     (id_rs_used),
    .id_rt_used     (id_rt_used),
    .exe_valid      (exe_valid),
    .exe_rdc        (exe_rdc),
    .exe_rdc_valid  (exe_rdc_valid),
    .exe_lw_instr   (exe_lw_instr),
    .load_use_stall (load_use_stall)
  );

  // Per-stage "done with current instruction".
  assign if_rg  = 1'b1;
  assign id_rg  = !load_use_stall;
  assign exe_rg = !exe_mul_instr || (mul_cnt == MUL_LAST);
  assign mem_rg = mem_ready_go;

  // A stage accepts when empty, or when its occupant is done and can move on.
  assign wb_allowin  = 1'b1;
  assign mem_allowin = !mem_valid || (mem_rg && wb_allowin);
  assign exe_allowin = !exe_valid || (exe_rg && mem_allowin);
  assign id_allowin  = !id_valid  || (id_rg  && exe_allowin);
  assign if_allowin  = !if_valid  || (if_rg  && id_allowin);

  assign pc_we = !rst && id_allowin && (!if_valid || if_rg);

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      if (flush) begin
        vld_q[STG_IF]  <= 1'b0;
        vld_q[STG_ID]  <= 1'b0;
        vld_q[STG_EXE] <= 1'b0;
      end else begin
        if (if_allowin)  vld_q[STG_IF]  <= 1'b1;
        if (id_allowin)  vld_q[STG_ID]  <= if_valid && if_rg;
        // With id_rg low this loads a bubble while EXE keeps flowing.
        if (exe_allowin) vld_q[STG_EXE] <= id_valid && id_rg;
      end
      // An instruction leaving a flushed EXE must not reach MEM.
      if (mem_allowin) vld_q[STG_MEM] <= exe_valid && exe_rg && !flush;
      if (wb_allowin)  vld_q[STG_WB]  <= mem_valid && mem_rg;
    end
  end

  // Counts cycles a mul has sat in EXE; stops at MUL_LAST because exe_rg
  // goes high there, so a MEM stall leaves it saturated until EXE drains.
  always_ff @(posedge clk) begin
    if (rst || flush || exe_allowin) begin
      mul_cnt <= '0;
    end else if (exe_valid && exe_mul_instr && !exe_rg) begin
      mul_cnt <= mul_cnt + CNT_W'(1);
    end
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic bubble_ins;

  assign bubble_ins = !id_rg && exe_allowin;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (id_valid && !id_allowin) stall_cnt  <= stall_cnt + 32'd1;
      if (bubble_ins)              bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, exe_rdc = '0;
  logic       id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic       exe_rdc_valid = 1'b0, exe_lw_instr = 1'b0, exe_mul_instr = 1'b0;
  logic       mem_ready_go = 1'b1;
  logic       pc_we, load_use_stall;
  logic       if_allowin, id_allowin, exe_allowin, mem_allowin, wb_allowin;
  logic       if_valid, id_valid, exe_valid, mem_valid, wb_valid;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int total = 0;
  int bad = 0;

  pipe_ctrl #(.MUL_CYCLES(3), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .exe_rdc(exe_rdc), .exe_rdc_valid(exe_rdc_valid),
    .exe_lw_instr(exe_lw_instr), .exe_mul_instr(exe_mul_instr),
    .mem_ready_go(mem_ready_go), .pc_we(pc_we),
    .if_allowin(if_allowin), .id_allowin(id_allowin), .exe_allowin(exe_allowin),
    .mem_allowin(mem_allowin), .wb_allowin(wb_allowin),
    .if_valid(if_valid), .id_valid(id_valid), .exe_valid(exe_valid),
    .mem_valid(mem_valid), .wb_valid(wb_valid),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
`endif
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       flush;
    logic       mul;
    logic       mrg;
    int         hz;
    logic       pc;
    logic [4:0] alw;   // {if,id,exe,mem,wb}
    logic [4:0] vld;   // {if,id,exe,mem,wb}
    logic       lus;
  } vec_t;

  vec_t vt[$];

  function automatic logic [4:0] alw_now();
    return {if_allowin, id_allowin, exe_allowin, mem_allowin, wb_allowin};
  endfunction

  function automatic logic [4:0] vld_now();
    return {if_valid, id_valid, exe_valid, mem_valid, wb_valid};
  endfunction

  task automatic add(input logic r, input logic f, input logic m, input logic g, input int hz,
                     input logic pc, input logic [4:0] alw, input logic [4:0] vld, input logic lus);
    vec_t v;
    v.rst = r; v.flush = f; v.mul = m; v.mrg = g; v.hz = hz;
    v.pc = pc; v.alw = alw; v.vld = vld; v.lus = lus;
    vt.push_back(v);
  endtask

  // Hazard input patterns:
  // 0 none; 1 lw $5 vs rs=$5 (stall); 2 lw $0 vs rs=$0 (no stall);
  // 3 lw $7, rs=$7 unused, rt=$3 (no stall); 4 lw $7 vs rt=$7 (stall);
  // 5 non-load writing $5 vs rs=$5 (no stall); 6 lw $5 with rdc_valid=0 (no stall)
  task automatic apply_hz(input int hz);
    exe_lw_instr = 1'b0; exe_rdc = 5'd0; exe_rdc_valid = 1'b0;
    id_rs = 5'd0; id_rs_used = 1'b0; id_rt = 5'd0; id_rt_used = 1'b0;
    case (hz)
      1: begin exe_lw_instr = 1'b1; exe_rdc = 5'd5; exe_rdc_valid = 1'b1; id_rs = 5'd5; id_rs_used = 1'b1; end
      2: begin exe_lw_instr = 1'b1; exe_rdc = 5'd0; exe_rdc_valid = 1'b1; id_rs = 5'd0; id_rs_used = 1'b1; end
      3: begin exe_lw_instr = 1'b1; exe_rdc = 5'd7; exe_rdc_valid = 1'b1; id_rs = 5'd7; id_rt = 5'd3; id_rt_used = 1'b1; end
      4: begin exe_lw_instr = 1'b1; exe_rdc = 5'd7; exe_rdc_valid = 1'b1; id_rt = 5'd7; id_rt_used = 1'b1; end
      5: begin exe_rdc = 5'd5; exe_rdc_valid = 1'b1; id_rs = 5'd5; id_rs_used = 1'b1; end
      6: begin exe_lw_instr = 1'b1; exe_rdc = 5'd5; id_rs = 5'd5; id_rs_used = 1'b1; end
      default: ;
    endcase
  endtask

  // Inputs change after the falling edge; outputs are sampled 1 time unit later.
  task automatic set_in(input logic r, input logic f, input logic m, input logic g, input int hz);
    @(negedge clk);
    rst = r; flush = f; exe_mul_instr = m; mem_ready_go = g;
    apply_hz(hz);
    #1;
  endtask

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  initial begin
    logic [4:0] ones;
    ones = 5'b11111;

    // rst, flush, mul, mrg, hz, pc, allowins, valids, lus
    add(1,0,0,1,0, 0, 5'b11111, 5'b00000, 0);  // in reset
    add(0,0,0,1,0, 1, 5'b11111, 5'b00000, 0);  // first cycle out of reset
    add(0,0,0,1,0, 1, 5'b11111, 5'b10000, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11000, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11100, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11111, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11111, 0);
    add(0,0,0,1,1, 0, 5'b00111, 5'b11111, 1);  // load-use on rs
    add(0,0,0,1,1, 1, 5'b11111, 5'b11011, 0);  // bubble in EXE
    add(0,0,0,1,0, 1, 5'b11111, 5'b11101, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);
    add(0,0,0,1,2, 1, 5'b11111, 5'b11111, 0);  // $0 never stalls
    add(0,0,0,1,5, 1, 5'b11111, 5'b11111, 0);  // not a load
    add(0,0,0,1,6, 1, 5'b11111, 5'b11111, 0);  // rdc not valid
    add(0,0,0,1,3, 1, 5'b11111, 5'b11111, 0);  // rs unused
    add(0,0,0,1,4, 0, 5'b00111, 5'b11111, 1);  // load-use on rt
    add(0,0,0,1,0, 1, 5'b11111, 5'b11011, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11101, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);
    add(0,0,1,1,0, 0, 5'b00011, 5'b11111, 0);  // mul cycle 1
    add(0,0,1,1,0, 0, 5'b00011, 5'b11101, 0);  // mul cycle 2
    add(0,0,1,1,0, 1, 5'b11111, 5'b11100, 0);  // mul cycle 3: leaves
    add(0,0,1,1,0, 0, 5'b00011, 5'b11110, 0);  // back-to-back mul restarts count
    add(0,0,1,1,0, 0, 5'b00011, 5'b11101, 0);
    add(0,0,1,1,0, 1, 5'b11111, 5'b11100, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);
    add(0,0,0,0,0, 0, 5'b00001, 5'b11111, 0);  // MEM stall x4
    add(0,0,0,0,0, 0, 5'b00001, 5'b11110, 0);
    add(0,0,0,0,0, 0, 5'b00001, 5'b11110, 0);
    add(0,0,0,0,0, 0, 5'b00001, 5'b11110, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);  // resume
    add(0,0,0,1,0, 1, 5'b11111, 5'b11111, 0);
    add(0,0,0,0,1, 0, 5'b00001, 5'b11111, 1);  // load-use + MEM stall: no bubble
    add(0,0,0,1,1, 0, 5'b00111, 5'b11110, 1);  // EXE drains, bubble now
    add(0,0,0,1,0, 1, 5'b11111, 5'b11011, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11101, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11110, 0);
    add(0,0,0,1,0, 1, 5'b11111, 5'b11111, 0);

    repeat (2) @(negedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      set_in(vt[i].rst, vt[i].flush, vt[i].mul, vt[i].mrg, vt[i].hz);
      chk($sformatf("v%0d_pc_we", i), {4'b0, pc_we}, {4'b0, vt[i].pc});
      chk($sformatf("v%0d_allowin", i), alw_now(), vt[i].alw);
      chk($sformatf("v%0d_valid", i), vld_now(), vt[i].vld);
      chk($sformatf("v%0d_lus", i), {4'b0, load_use_stall}, {4'b0, vt[i].lus});
    end

    // Mul counter saturates while MEM stalls, so EXE releases as soon as MEM does.
    for (int c = 0; c < 4; c++) begin
      set_in(0,0,1,0,0);
      chk($sformatf("sat%0d_allowin", c), alw_now(), 5'b00001);
    end
    set_in(0,0,1,1,0);
    chk("sat_release_allowin", alw_now(), 5'b11111);
    chk("sat_release_valid", vld_now(), 5'b11110);

    // Flush in the middle of a mul.
    set_in(0,0,1,1,0);
    chk("fmul_pre_allowin", alw_now(), 5'b00011);
    set_in(0,1,1,1,0);
    chk("fmul_flush_valid", vld_now(), 5'b11101);
    set_in(0,0,0,1,0);
    chk("fmul_post_valid", vld_now(), 5'b00000);
    chk("fmul_post_allowin", alw_now(), 5'b11111);
    chk("fmul_post_pc_we", {4'b0, pc_we}, 5'b00001);
    for (int k = 0; k < 5; k++) begin
      set_in(0,0,0,1,0);
      chk($sformatf("refill%0d_valid", k), vld_now(), ~(ones >> (k + 1)));
    end
    // A fresh mul after the flush takes the full three cycles.
    for (int k = 0; k < 3; k++) begin
      set_in(0,0,1,1,0);
      chk($sformatf("mul_after_flush%0d_exe_allowin", k), {4'b0, exe_allowin}, (k == 2) ? 5'b00001 : 5'b00000);
    end
    set_in(0,0,0,1,0);
    chk("mul_after_flush_valid", vld_now(), 5'b11110);

    // Flush with a full pipe: the instruction leaving EXE is killed, MEM's moves to WB.
    set_in(0,1,0,1,0);
    chk("flush_full_pre", vld_now(), 5'b11111);
    set_in(0,0,0,1,0);
    chk("flush_full_post", vld_now(), 5'b00001);
    set_in(0,0,0,1,0);
    set_in(0,0,0,1,0);

    // Reset wins over a concurrent flush.
    set_in(1,1,0,1,0);
    chk("rstflush_pc_we", {4'b0, pc_we}, 5'b00000);
    chk("rstflush_pre_valid", vld_now(), 5'b11100);
    set_in(0,0,0,1,0);
    chk("rstflush_valid", vld_now(), 5'b00000);
    chk("rstflush_post_pc_we", {4'b0, pc_we}, 5'b00001);
    set_in(0,0,0,1,0);
    chk("rstflush_if_valid", vld_now(), 5'b10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Valid/allowin handshake controller for the 5-stage pipeline (IF, ID, EXE, MEM, WB).
- Owns one valid bit per stage and produces the per-stage allowin enables that gate the stage pipeline registers, including the EXE register's exe_allowin.
- Detects load-use hazards between ID and EXE and inserts bubbles.
- Sequences multi-cycle multiplies held in EXE.
- Handles a pipeline flush.

Parameters:
- MUL_CYCLES, 3, cycles a mul instruction occupies EXE (>=1; 1 = single-cycle).
- CNT_W, 2, width of the mul cycle counter; must satisfy 2^CNT_W >= MUL_CYCLES.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  clears IF/ID/EXE valids (exception/eret redirect).
- id_rs  in  5  rs address of instruction in ID.
- id_rt  in  5  rt address of instruction in ID.
- id_rs_used  in  1  ID instruction reads rs.
- id_rt_used  in  1  ID instruction reads rt.
- exe_rdc  in  5  destination register of instruction in EXE.
- exe_rdc_valid  in  1  EXE instruction writes exe_rdc.
- exe_lw_instr  in  1  EXE instruction is a load.
- exe_mul_instr  in  1  EXE instruction is a multi-cycle mul.
- mem_ready_go  in  1  MEM stage may hand off (data memory done).
- pc_we  out  1  PC register write enable.
- if_allowin, id_allowin, exe_allowin, mem_allowin, wb_allowin  out  1 each  load enables for stage registers.
- if_valid, id_valid, exe_valid, mem_valid, wb_valid  out  1 each  stage holds a live instruction.
- load_use_stall  out  1  ID held this cycle by a load-use hazard.

Behaviour:
- All valids are registered. All allowins, pc_we and load_use_stall are combinational from the current state and inputs.
- Per-stage ready_go:
  - if_rg = 1
  - id_rg = !load_use_stall
  - exe_rg = !exe_mul_instr || mul_cnt == MUL_CYCLES-1
  - mem_rg = mem_ready_go
  - wb_rg = 1
- allowin chain:
  - wb_allowin = 1
  - For each other stage s with successor n: s_allowin = !s_valid || (s_rg && n_allowin).
- pc_we = !rst && id_allowin && (!if_valid || if_rg); combinationally forced to 0 while rst=1.
- Valid updates on posedge, for each stage s with predecessor p:
  - if s_allowin: s_valid <= p_valid && p_rg.
  - else: s_valid holds.
  - IF's predecessor is the always-valid PC: if_valid <= 1 when if_allowin.
- Bubble insertion: when id_rg=0 and exe_allowin=1, exe_valid becomes 0 next cycle. exe_allowin stays 1, so the EXE register loads, but it loads a bubble (rf_we/dmem_we must be qualified by exe_valid downstream).
- load_use_stall = id_valid && exe_valid && exe_lw_instr && exe_rdc_valid && exe_rdc != 0 && ((id_rs_used && id_rs == exe_rdc) || (id_rt_used && id_rt == exe_rdc)).
- A register-0 destination never stalls.
- Mul counter mul_cnt (CNT_W bits):
  - Reset to 0 on rst, on flush, or whenever exe_allowin=1.
  - Increments while exe_valid && exe_mul_instr && !exe_rg.
  - A mul therefore leaves EXE exactly MUL_CYCLES cycles after entering, provided MEM accepts.
  - If MEM then stalls, mul_cnt saturates at MUL_CYCLES-1.
- Flush:
  - if_valid, id_valid and exe_valid <= 0 next cycle; mul_cnt <= 0.
  - mem_valid/wb_valid update normally, and mem_valid takes 0 if EXE was being flushed this cycle.
- Priority: rst > flush > normal update.
- Reset:
  - All valids and mul_cnt are 0.
  - On the first cycle after rst falls, pc_we=1; if_valid=1 on the following edge.
- Simultaneous load_use_stall and MEM stall: exe_allowin=0, so EXE holds the load and ID holds. No bubble is generated until EXE drains.

Optional Feature:
- Macro PIPE_CTRL_PERF_CNT_EN.
- When defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - Both are reset to 0 by rst.
  - stall_cnt increments every cycle id_valid && !id_allowin.
  - bubble_cnt increments every cycle a bubble is inserted into EXE.
  - Both wrap at 2^32.
- When undefined: the ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - REG_ZERO = 5'd0
  - stage index constants STG_IF..STG_WB
  - the default MUL_CYCLES constant.
- One sub-module, load_use_detect: the purely combinational hazard compare producing load_use_stall, reused later by the forwarding unit.

Test Plan:
- Reset then free-run, mem_ready_go=1, no hazards -> if_valid=1 at cycle 2; wb_valid=1 at cycle 6; all allowins stay 1; pc_we=1 each cycle.
- lw $5 in EXE (exe_lw_instr=1, exe_rdc=5, exe_rdc_valid=1), ID with id_rs=5, id_rs_used=1 -> load_use_stall=1, id_allowin=0, pc_we=0 for one cycle; next cycle exe_valid=0 (bubble); ID proceeds after.
- Same load with exe_rdc=0, or id_rs_used=0 -> no stall.
- Mul in EXE, MUL_CYCLES=3 -> exe_allowin=0 and id_allowin=0 for 2 cycles; mem_valid rises on the 3rd edge; mul_cnt returns to 0.
- mem_ready_go=0 for 4 cycles with a full pipe -> mem/exe/id/if allowin all 0; valids hold; wb_valid falls to 0 next cycle; everything resumes when mem_ready_go=1.
- flush during a mul stall -> if/id/exe valids 0 next cycle; mem_valid=0; mul_cnt=0; rst asserted concurrently with flush -> all valids 0.
